code_lock_fsm: RTL and testbench
================================

Name: code_lock_fsm

Overview:
Parametrised successor to the fixed four-button A-B-C-D lock. Accepts presses on NUM_KEYS debounced key lines and matches them against a CODE_LEN-symbol code held in registers. The code can be reprogrammed while the lock is open. Adds a failed-attempt lockout, auto-relock and an explicit relock input, and drives the same active-low 7-segment glyph port as the current lock (one clock domain, after the per-key debouncers).

Parameters:
NUM_KEYS, 4, number of key inputs (2..16); KEY_W = max(1, $clog2(NUM_KEYS)) is derived.
CODE_LEN, 4, symbols per code (1..8).
DEFAULT_CODE, 8'hE4, reset code, CODE_LEN*KEY_W bits; symbol i at [i*KEY_W +: KEY_W]; the default is the sequence 0,1,2,3.
MAX_TRIES, 3, consecutive wrong presses that trigger lockout (>=1).
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (>=1).
OPEN_CYCLES, 0, auto-relock timeout in cycles; 0 disables auto-relock.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
keys  in  NUM_KEYS  debounced key levels, bit k = key k
relock  in  1  level; forces OPEN->LOCKED
prog_req  in  1  level; OPEN->PROG
O  out  7  active-low segment glyph {a,b,c,d,e,f,g}
unlocked  out  1  high in OPEN
locked_out  out  1  high in LOCKOUT
progress  out  $clog2(CODE_LEN+1)  symbols matched or entered so far

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; it takes effect at a clk edge.
- Reset values: state=LOCKED; code=DEFAULT_CODE; progress=0; fail_cnt=0; all timers=0; keys_prev=all ones, so a key held through reset produces no press; O=7'b1110001; unlocked=0; locked_out=0.
- Press detection:
  - rise = keys & ~keys_prev, registered each cycle.
  - A valid press is rise with exactly one bit set; sym = index of that bit.
  - rise with two or more bits set is a "bad press": a mismatch in LOCKED, ignored in PROG.
  - rise==0 means no event.
- Latency: a press whose key is first high at edge k updates state, progress and outputs at edge k. Outputs are decoded from registered state; there are no combinational paths from inputs.
- States:
  - LOCKED (O=1110001 "L"):
    - Valid press with sym==code[progress]: progress++. If progress reaches CODE_LEN, go to OPEN, clear progress and fail_cnt.
    - Mismatch: fail_cnt++. progress becomes 1 if sym==code[0], else 0.
    - When fail_cnt reaches MAX_TRIES: go to LOCKOUT, progress=0, lockout timer=LOCKOUT_CYCLES-1.
  - LOCKOUT (O=0110000 "E"):
    - All presses ignored.
    - Timer decrements each cycle; at 0, go to LOCKED with fail_cnt=0.
  - OPEN (O=1000001 "U"):
    - Presses ignored.
    - Priority: relock, then prog_req.
    - relock=1: go to LOCKED.
    - prog_req=1: go to PROG, progress=0.
    - If OPEN_CYCLES!=0: the open timer loads OPEN_CYCLES-1 on entry and decrements; at 0, go to LOCKED.
  - PROG (O=0011000 "P"):
    - Each valid press writes code[progress]=sym, then progress++.
    - After the CODE_LEN-th write: go to LOCKED, progress=0. The new code is active from the next cycle.
    - relock in PROG aborts to LOCKED; symbols already written are kept.
- Code storage: in PROG the press is written to code[progress] and the completion check happens at the same edge. Match comparisons always use the registered code.
- Counter saturation: fail_cnt and progress never exceed MAX_TRIES and CODE_LEN respectively.
- rst mid-operation, in any state including PROG: returns to the reset values above, and the code reverts to DEFAULT_CODE.

Decomposition:
- Package code_lock_pkg holds:
  - state enum {LOCKED, OPEN, LOCKOUT, PROG};
  - glyph constants SEG_L=7'b1110001, SEG_U=7'b1000001, SEG_E=7'b0110000, SEG_P=7'b0011000;
  - function onehot_to_idx, which returns an index plus a valid flag.
- Sub-module key_event, parametrised by NUM_KEYS, contains keys_prev, rise, the single-bit check and index encoding. Its outputs are press_valid, press_bad and sym.

Test Plan:
1. Defaults, reset then press keys 0,1,2,3 one at a time, each held 3 cycles with 2 low cycles between -> progress steps 1..4. unlocked=1 and O=1000001 at the edge of key 3's rise.
2. Enter 0,1,3: the mismatch sets progress=0 and fail_cnt=1. Then 0,1,0: progress=1. Then 2 → 3rd fail -> locked_out=1, O=0110000, keys ignored for exactly 1000 cycles, then LOCKED with O=1110001.
3. Keys 1 and 2 rising in the same cycle while in LOCKED at progress=2 -> treated as a mismatch, progress=0, fail_cnt increments.
4. Open the lock, set prog_req=1, enter 3,3,0,1 -> state LOCKED with code=8'h4F. Entering 0,1,2,3 then fails; entering 3,3,0,1 opens the lock.
5. OPEN_CYCLES=20: open the lock -> unlocked drops exactly 20 cycles after opening. Separately, relock=1 in OPEN -> LOCKED on the next edge.
6. Key 0 held high across the rst deassert -> no progress. Assert rst mid-PROG after 2 writes -> code==8'hE4 and O=1110001.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared types, glyph constants and the one-hot index helper for the code lock.
package code_lock_pkg;

    // Top-level lock states.
    typedef enum logic [1:0] {
        LOCKED  = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2,
        PROG    = 2'd3
    } state_t;

    // Active-low 7-segment glyphs, bit order {a,b,c,d,e,f,g}.
    localparam logic [6:0] SEG_L = 7'b1110001;
    localparam logic [6:0] SEG_U = 7'b1000001;
    localparam logic [6:0] SEG_E = 7'b0110000;
    localparam logic [6:0] SEG_P = 7'b0011000;

    // Widest symbol index supported (NUM_KEYS up to 16).
    localparam int SYM_W = 4;

    typedef struct packed {
        logic             valid;
        logic [SYM_W-1:0] idx;
    } onehot_idx_t;

    // Index of the single set bit; valid is low when zero or several bits are set.
    function automatic onehot_idx_t onehot_to_idx(input logic [15:0] v);
        onehot_idx_t r;
        int          n;
        r = '0;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) begin
                n++;
                r.idx = SYM_W'(i);
            end
        end
        r.valid = (n == 1);
        return r;
    endfunction

endpackage

// File: rtl/code_lock_fsm_if.sv
// Key/control inputs and status outputs of the code lock, grouped as one bundle.
interface code_lock_fsm_if #(
    parameter int NUM_KEYS = 4,
    parameter int CODE_LEN = 4
);
    logic [NUM_KEYS-1:0]               keys;
    logic                              relock;
    logic                              prog_req;
    logic [6:0]                        O;
    logic                              unlocked;
    logic                              locked_out;
    logic [$clog2(CODE_LEN+1)-1:0]     progress;

    // Driver side (keypad / test environment).
    modport master (
        output keys, relock, prog_req,
        input  O, unlocked, locked_out, progress
    );

    // Lock side.
    modport slave (
        input  keys, relock, prog_req,
        output O, unlocked, locked_out, progress
    );
endinterface

// File: rtl/key_event.sv
// Turns debounced key levels into single-key press events with a symbol index.
module key_event
    import code_lock_pkg::*;
#(
    parameter int NUM_KEYS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys_i,
    output logic                press_valid_o,
    output logic                press_bad_o,
    output logic [SYM_W-1:0]    sym_o
);

    logic [NUM_KEYS-1:0] keys_prev_q;
    logic [NUM_KEYS-1:0] rise;
    logic [15:0]         rise_ext;
    onehot_idx_t         oh;

    // Previous key levels; all ones in reset so a key held through reset is not a press.
    always_ff @(posedge clk) begin
        if (rst) keys_prev_q <= '1;
        else     keys_prev_q <= keys_i;
    end

    // Rising-edge detect and classification into valid / multi-key presses.
    always_comb begin
        rise                     = keys_i & ~keys_prev_q;
        rise_ext                 = '0;
        rise_ext[NUM_KEYS-1:0]   = rise;
        oh                       = onehot_to_idx(rise_ext);
        press_valid_o            = oh.valid;
        press_bad_o              = (rise != '0) && !oh.valid;
        sym_o                    = oh.idx;
    end

endmodule

// File: rtl/code_lock_fsm.sv
// Programmable key-code lock with failed-attempt lockout and auto/explicit relock.
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int NUM_KEYS       = 4,
    parameter int CODE_LEN       = 4,
    parameter     DEFAULT_CODE   = 8'hE4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 1000,
    parameter int OPEN_CYCLES    = 0
) (
    input  logic            clk,
    input  logic            rst,
    code_lock_fsm_if.slave  bus
);

    localparam int KEY_W = (NUM_KEYS > 2) ? $clog2(NUM_KEYS) : 1;
    localparam int CW    = CODE_LEN * KEY_W;
    localparam int PW    = $clog2(CODE_LEN + 1);
    localparam int FW    = $clog2(MAX_TRIES + 1);
    localparam int LW    = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam int OW    = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;

    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [OW-1:0] OPEN_LOAD = OW'((OPEN_CYCLES > 0) ? OPEN_CYCLES - 1 : 0);

    state_t           state_q, state_d;
    logic [CW-1:0]    code_q, code_d;
    logic [PW-1:0]    progress_q, progress_d;
    logic [FW-1:0]    fail_q, fail_d;
    logic [LW-1:0]    lock_tmr_q, lock_tmr_d;
    logic [OW-1:0]    open_tmr_q, open_tmr_d;

    logic             press_valid;
    logic             press_bad;
    logic [SYM_W-1:0] sym;

    key_event #(.NUM_KEYS(NUM_KEYS)) u_key_event (
        .clk           (clk),
        .rst           (rst),
        .keys_i        (bus.keys),
        .press_valid_o (press_valid),
        .press_bad_o   (press_bad),
        .sym_o         (sym)
    );

    // Code symbol at a given position, zero-extended to the press symbol width.
    function automatic logic [SYM_W-1:0] sym_at(input logic [CW-1:0] code,
                                                input logic [PW-1:0] idx);
        logic [SYM_W-1:0] r;
        r = '0;
        for (int i = 0; i < CODE_LEN; i++) begin
            if (idx == PW'(i)) r = SYM_W'(code[i*KEY_W +: KEY_W]);
        end
        return r;
    endfunction

    // State, code and counter registers; reset also restores the default code.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOCKED;
            code_q     <= CW'(DEFAULT_CODE);
            progress_q <= '0;
            fail_q     <= '0;
            lock_tmr_q <= '0;
            open_tmr_q <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            progress_q <= progress_d;
            fail_q     <= fail_d;
            lock_tmr_q <= lock_tmr_d;
            open_tmr_q <= open_tmr_d;
        end
    end

    // Next-state logic: matching, lockout timing, open timeout and programming.
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        progress_d = progress_q;
        fail_d     = fail_q;
        lock_tmr_d = lock_tmr_q;
        open_tmr_d = open_tmr_q;
        case (state_q)
            LOCKED: begin
                if (press_valid && sym == sym_at(code_q, progress_q)) begin
                    if (progress_q == PW'(CODE_LEN - 1)) begin
                        state_d    = OPEN;
                        progress_d = '0;
                        fail_d     = '0;
                        open_tmr_d = OPEN_LOAD;
                    end else begin
                        progress_d = progress_q + PW'(1);
                    end
                end else if (press_valid || press_bad) begin
                    // A wrong key may still be the first symbol of a fresh attempt.
                    progress_d = (press_valid && sym == sym_at(code_q, '0)) ? PW'(1) : '0;
                    if (fail_q == FW'(MAX_TRIES - 1)) begin
                        state_d    = LOCKOUT;
                        progress_d = '0;
                        fail_d     = FW'(MAX_TRIES);
                        lock_tmr_d = LOCK_LOAD;
                    end else begin
                        fail_d = fail_q + FW'(1);
                    end
                end
            end
            LOCKOUT: begin
                if (lock_tmr_q == '0) begin
                    state_d = LOCKED;
                    fail_d  = '0;
                end else begin
                    lock_tmr_d = lock_tmr_q - LW'(1);
                end
            end
            OPEN: begin
                if (bus.relock) begin
                    state_d = LOCKED;
                end else if (bus.prog_req) begin
                    state_d    = PROG;
                    progress_d = '0;
                end else if (OPEN_CYCLES != 0) begin
                    if (open_tmr_q == '0) state_d = LOCKED;
                    else                  open_tmr_d = open_tmr_q - OW'(1);
                end
            end
            PROG: begin
                if (bus.relock) begin
                    state_d    = LOCKED;
                    progress_d = '0;
                end else if (press_valid) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (progress_q == PW'(i)) code_d[i*KEY_W +: KEY_W] = sym[KEY_W-1:0];
                    end
                    if (progress_q == PW'(CODE_LEN - 1)) begin
                        state_d    = LOCKED;
                        progress_d = '0;
                    end else begin
                        progress_d = progress_q + PW'(1);
                    end
                end
            end
            default: state_d = LOCKED;
        endcase
    end

    // Status outputs decoded from registered state only.
    always_comb begin
        bus.O          = SEG_L;
        bus.unlocked   = 1'b0;
        bus.locked_out = 1'b0;
        bus.progress   = progress_q;
        case (state_q)
            OPEN:    begin bus.O = SEG_U; bus.unlocked   = 1'b1; end
            LOCKOUT: begin bus.O = SEG_E; bus.locked_out = 1'b1; end
            PROG:    bus.O = SEG_P;
            default: bus.O = SEG_L;
        endcase
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them.
module tb_code_lock_fsm;

    localparam logic [6:0] G_L = 7'b1110001;
    localparam logic [6:0] G_U = 7'b1000001;
    localparam logic [6:0] G_E = 7'b0110000;
    localparam logic [6:0] G_P = 7'b0011000;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_t;
    int   t;

    typedef struct {
        int         cyc;
        string      name;
        logic [6:0] o;
        logic       u;
        logic       l;
        logic [2:0] p;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    code_lock_fsm_if #(.NUM_KEYS(4), .CODE_LEN(4)) bus ();

    code_lock_fsm #(.OPEN_CYCLES(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            checks++;
            if (mon_e.cyc != cyc || bus.O !== mon_e.o || bus.unlocked !== mon_e.u ||
                bus.locked_out !== mon_e.l || bus.progress !== mon_e.p) begin
                errors++;
                $display("FAIL %s cyc=%0d: got O=%b unlocked=%b locked_out=%b progress=%0d, want O=%b unlocked=%b locked_out=%b progress=%0d (due cyc %0d)",
                         mon_e.name, cyc, bus.O, bus.unlocked, bus.locked_out, bus.progress,
                         mon_e.o, mon_e.u, mon_e.l, mon_e.p, mon_e.cyc);
            end
        end
    end

    task automatic expect_at(input int c, input string nm, input logic [6:0] o,
                             input logic u, input logic l, input logic [2:0] p);
        sb.push_back('{c, nm, o, u, l, p});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One key press: 3 cycles high, 2 low; expected state checked at the rise edge and after release.
    task automatic press(input int k, input string nm, input logic [6:0] o,
                         input logic u, input logic l, input logic [2:0] p);
        bus.keys = 4'(1 << k);
        last_t   = cyc + 1;
        expect_at(cyc + 1, nm, o, u, l, p);
        expect_at(cyc + 5, {nm, "_hold"}, o, u, l, p);
        tick(3);
        bus.keys = '0;
        tick(2);
    endtask

    task automatic open_with_3301(input string nm);
        press(3, {nm, "_a"}, G_L, 0, 0, 1);
        press(3, {nm, "_b"}, G_L, 0, 0, 2);
        press(0, {nm, "_c"}, G_L, 0, 0, 3);
        press(1, {nm, "_open"}, G_U, 1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.keys     = '0;
        bus.relock   = 1'b0;
        bus.prog_req = 1'b0;
        tick(3);
        rst = 1'b0;
        expect_at(cyc + 1, "reset_state", G_L, 0, 0, 0);
        tick(1);

        // Default code 0,1,2,3 opens
        press(0, "t1_k0", G_L, 0, 0, 1);
        press(1, "t1_k1", G_L, 0, 0, 2);
        press(2, "t1_k2", G_L, 0, 0, 3);
        press(3, "t1_open", G_U, 1, 0, 0);
        t = last_t;

        // Auto-relock exactly 20 cycles after opening
        expect_at(t + 19, "t5_open_last", G_U, 1, 0, 0);
        expect_at(t + 20, "t5_autorelock", G_L, 0, 0, 0);
        tick(t + 21 - cyc);

        // Three wrong presses -> lockout for 1000 cycles
        press(0, "t2_a0", G_L, 0, 0, 1);
        press(1, "t2_a1", G_L, 0, 0, 2);
        press(3, "t2_fail1", G_L, 0, 0, 0);
        press(0, "t2_b0", G_L, 0, 0, 1);
        press(1, "t2_b1", G_L, 0, 0, 2);
        press(0, "t2_fail2_restart", G_L, 0, 0, 1);
        press(2, "t2_lockout", G_E, 0, 1, 0);
        t = last_t;
        press(0, "t2_ignored", G_E, 0, 1, 0);
        expect_at(t + 999, "t2_lockout_last", G_E, 0, 1, 0);
        expect_at(t + 1000, "t2_lockout_end", G_L, 0, 0, 0);
        tick(t + 1001 - cyc);

        // Two keys rising together count as a mismatch; fail count was cleared by lockout exit
        press(0, "t3_k0", G_L, 0, 0, 1);
        press(1, "t3_k1", G_L, 0, 0, 2);
        bus.keys = 4'b0110;
        expect_at(cyc + 1, "t3_bad_press", G_L, 0, 0, 0);
        tick(3);
        bus.keys = '0;
        tick(2);
        press(3, "t3_fail2", G_L, 0, 0, 0);
        press(3, "t3_fail3", G_E, 0, 1, 0);
        t = last_t;
        expect_at(t + 1000, "t3_lockout_end", G_L, 0, 0, 0);
        tick(t + 1001 - cyc);

        // Reprogram to 3,3,0,1
        press(0, "t4_k0", G_L, 0, 0, 1);
        press(1, "t4_k1", G_L, 0, 0, 2);
        press(2, "t4_k2", G_L, 0, 0, 3);
        press(3, "t4_open", G_U, 1, 0, 0);
        bus.prog_req = 1'b1;
        expect_at(cyc + 1, "t4_enter_prog", G_P, 0, 0, 0);
        tick(1);
        bus.prog_req = 1'b0;
        press(3, "t4_w0", G_P, 0, 0, 1);
        press(3, "t4_w1", G_P, 0, 0, 2);
        press(0, "t4_w2", G_P, 0, 0, 3);
        press(1, "t4_prog_done", G_L, 0, 0, 0);
        press(0, "t4_old0_fails", G_L, 0, 0, 0);
        press(1, "t4_old1_fails", G_L, 0, 0, 0);
        open_with_3301("t4_new");

        // Explicit relock from OPEN
        bus.relock = 1'b1;
        expect_at(cyc + 1, "t5_relock", G_L, 0, 0, 0);
        tick(1);
        bus.relock = 1'b0;

        // Reset in PROG restores default code; key held through reset is no press
        open_with_3301("t6");
        bus.prog_req = 1'b1;
        expect_at(cyc + 1, "t6_enter_prog", G_P, 0, 0, 0);
        tick(1);
        bus.prog_req = 1'b0;
        press(2, "t6_w0", G_P, 0, 0, 1);
        press(2, "t6_w1", G_P, 0, 0, 2);
        rst      = 1'b1;
        bus.keys = 4'b0001;
        expect_at(cyc + 1, "t6_rst_in_prog", G_L, 0, 0, 0);
        tick(2);
        rst = 1'b0;
        expect_at(cyc + 1, "t6_held_key_no_press", G_L, 0, 0, 0);
        expect_at(cyc + 3, "t6_held_key_still", G_L, 0, 0, 0);
        tick(3);
        bus.keys = '0;
        tick(2);
        press(0, "t6_d0", G_L, 0, 0, 1);
        press(1, "t6_d1", G_L, 0, 0, 2);
        press(2, "t6_d2", G_L, 0, 0, 3);
        press(3, "t6_default_open", G_U, 1, 0, 0);

        tick(3);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
